// File: rtl/udp_reg_ring_master_pkg.sv
// Shared widths, encodings and helpers for the user-datapath register ring master.
// Width macros are defined here only if the surrounding project has not already done so.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif

`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

`ifndef LOG2_FUNC
`define LOG2_FUNC \
  function automatic int unsigned log2(input int unsigned value); \
    int unsigned bits; \
    bits = 0; \
    while ((64'd1 << bits) < 64'(value)) bits = bits + 1; \
    return bits; \
  endfunction
`endif

package udp_reg_ring_master_pkg;

  localparam int unsigned ADDR_W   = `UDP_REG_ADDR_WIDTH;
  localparam int unsigned DATA_W   = `CPCI_NF2_DATA_WIDTH;
  localparam int unsigned STATUS_W = 2;

  localparam logic [DATA_W-1:0] DEFAULT_NOACK_DATA   = DATA_W'(32'hDEAD_0001);
  localparam logic [DATA_W-1:0] DEFAULT_TIMEOUT_DATA = DATA_W'(32'hDEAD_0000);

  typedef enum logic [STATUS_W-1:0] {
    STATUS_OK      = 2'b00,
    STATUS_NOACK   = 2'b01,
    STATUS_TIMEOUT = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Request payload driven into the head of the ring (source tag kept separate,
  // its width is a module parameter).
  typedef struct packed {
    logic              req;
    logic              ack;
    logic              rd_wr_L;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ring_cmd_t;

  `LOG2_FUNC

endpackage

// File: rtl/udp_reg_ring_master.sv
// Register ring master: launches one host access into the ring head, collects it at the tail,
// and reports data/status (ok, no-ack, timeout) back to the host.
module udp_reg_ring_master
  import udp_reg_ring_master_pkg::*;
#(
  parameter int unsigned                   UDP_REG_SRC_WIDTH = 2,
  parameter logic [UDP_REG_SRC_WIDTH-1:0]  SRC_ID            = '0,
  parameter int unsigned                   TIMEOUT           = 1024,
  parameter logic [DATA_W-1:0]             NOACK_DATA        = DEFAULT_NOACK_DATA,
  parameter logic [DATA_W-1:0]             TIMEOUT_DATA      = DEFAULT_TIMEOUT_DATA
) (
  input  logic                          clk,
  input  logic                          reset,

  input  logic                          core_reg_req,
  input  logic                          core_reg_rd_wr_L,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]  core_reg_addr,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0] core_reg_wr_data,
  output logic                          core_reg_busy,
  output logic                          core_reg_ack,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0] core_reg_rd_data,
  output logic [1:0]                    core_reg_status,

  output logic                          reg_req_out,
  output logic                          reg_ack_out,
  output logic                          reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_out,

  input  logic                          reg_req_in,
  input  logic                          reg_ack_in,
  input  logic                          reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_in
);

  localparam int unsigned          TIMER_W    = log2(TIMEOUT) + 1;
  localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  state_e                       state_q, state_d;
  logic [TIMER_W-1:0]           timer_q, timer_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  ring_cmd_t                    ring_q, ring_d;
  logic [UDP_REG_SRC_WIDTH-1:0] src_q, src_d;
  logic                         busy_q, busy_d;
  logic                         ack_q, ack_d;
  logic [DATA_W-1:0]            rd_data_q, rd_data_d;
  logic [STATUS_W-1:0]          status_q, status_d;
  logic                         match_c;

  // Direction of the returning request carries no information for the master.
  logic unused_rd_wr_l_in;
  assign unused_rd_wr_l_in = reg_rd_wr_L_in;

  // Only our own request (same source tag and address) may terminate the wait.
  assign match_c = reg_req_in && (reg_src_in == SRC_ID) && (reg_addr_in == addr_q);

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      addr_q    <= '0;
      ring_q    <= '0;
      src_q     <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      rd_data_q <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      addr_q    <= addr_d;
      ring_q    <= ring_d;
      src_q     <= src_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      rd_data_q <= rd_data_d;
      status_q  <= status_d;
    end
  end

  // Next-state and next-output logic; ring outputs are nonzero only while in ISSUE.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    addr_d    = addr_q;
    ring_d    = '0;
    src_d     = '0;
    ack_d     = 1'b0;
    rd_data_d = rd_data_q;
    status_d  = status_q;

    case (state_q)
      ST_IDLE: begin
        if (core_reg_req) begin
          addr_d         = core_reg_addr;
          ring_d.req     = 1'b1;
          ring_d.rd_wr_L = core_reg_rd_wr_L;
          ring_d.addr    = core_reg_addr;
          ring_d.data    = core_reg_rd_wr_L ? '0 : core_reg_wr_data;
          src_d          = SRC_ID;
          state_d        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (match_c) begin
          ack_d     = 1'b1;
          rd_data_d = reg_ack_in ? reg_data_in : NOACK_DATA;
          status_d  = reg_ack_in ? STATUS_OK : STATUS_NOACK;
          state_d   = ST_RESP;
        end else if (timer_q == TIMER_LAST) begin
          ack_d     = 1'b1;
          rd_data_d = TIMEOUT_DATA;
          status_d  = STATUS_TIMEOUT;
          state_d   = ST_RESP;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign core_reg_busy    = busy_q;
  assign core_reg_ack     = ack_q;
  assign core_reg_rd_data = rd_data_q;
  assign core_reg_status  = status_q;

  assign reg_req_out      = ring_q.req;
  assign reg_ack_out      = ring_q.ack;
  assign reg_rd_wr_L_out  = ring_q.rd_wr_L;
  assign reg_addr_out     = ring_q.addr;
  assign reg_data_out     = ring_q.data;
  assign reg_src_out      = src_q;

endmodule

// File: tb/tb_udp_reg_ring_master.sv
// Self-checking bench for udp_reg_ring_master: a 3-stage ring model with eight registers at
// 0x10..0x80, plus a plain address->data table as the reference for expected results.
module tb_udp_reg_ring_master;

  localparam logic [1:0]  MY_SRC     = 2'd1;
  localparam int          TMO        = 16;
  localparam int          RING_DELAY = 3;
  localparam int          BUDGET     = 64;
  localparam logic [31:0] NOACK_VAL  = 32'hDEAD_0001;
  localparam logic [31:0] TMO_VAL    = 32'hDEAD_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        core_reg_req, core_reg_rd_wr_L;
  logic [22:0] core_reg_addr;
  logic [31:0] core_reg_wr_data;
  logic        core_reg_busy, core_reg_ack;
  logic [31:0] core_reg_rd_data;
  logic [1:0]  core_reg_status;
  logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [22:0] reg_addr_out;
  logic [31:0] reg_data_out;
  logic [1:0]  reg_src_out;
  logic        reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [22:0] reg_addr_in;
  logic [31:0] reg_data_in;
  logic [1:0]  reg_src_in;

  udp_reg_ring_master #(
    .UDP_REG_SRC_WIDTH(2),
    .SRC_ID(MY_SRC),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .core_reg_req(core_reg_req), .core_reg_rd_wr_L(core_reg_rd_wr_L),
    .core_reg_addr(core_reg_addr), .core_reg_wr_data(core_reg_wr_data),
    .core_reg_busy(core_reg_busy), .core_reg_ack(core_reg_ack),
    .core_reg_rd_data(core_reg_rd_data), .core_reg_status(core_reg_status),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in)
  );

  logic [95:0] all_out;
  assign all_out = {core_reg_busy, core_reg_ack, core_reg_rd_data, core_reg_status,
                    reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out,
                    reg_src_out};

  // Ring environment: eight registers behind a fixed 3-cycle pipe, with drop and inject hooks.
  typedef struct packed {
    logic req, ack, rd_wr_L;
    logic [22:0] addr;
    logic [31:0] data;
    logic [1:0]  src;
  } pkt_t;

  pkt_t        pipe0, pipe1, pipe2, inj;
  logic        inj_valid, drop_mode, ring_init;
  logic [31:0] ring_regs [8];

  function automatic int ring_index(input logic [22:0] a);
    if (a[22:8] == 15'd0 && a[3:0] == 4'd0 && a[7:4] != 4'd0 && a[7:4] <= 4'd8)
      return int'(a[7:4]) - 1;
    return -1;
  endfunction

  function automatic pkt_t ring_respond();
    pkt_t p;
    p = {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out};
    if (p.req && ring_index(p.addr) >= 0) begin
      p.ack = 1'b1;
      if (p.rd_wr_L) p.data = ring_regs[ring_index(p.addr)];
    end
    if (drop_mode) p = '0;
    return p;
  endfunction

  always @(posedge clk) begin
    if (ring_init) begin
      pipe0 <= '0; pipe1 <= '0; pipe2 <= '0;
      for (int i = 0; i < 8; i++) ring_regs[i] <= (i == 0) ? 32'h1234_5678 : (32'hA5A5_0000 | 32'(i));
    end else begin
      if (reg_req_out && !reg_rd_wr_L_out && !drop_mode && ring_index(reg_addr_out) >= 0)
        ring_regs[ring_index(reg_addr_out)] <= reg_data_out;
      pipe0 <= ring_respond();
      pipe1 <= pipe0;
      pipe2 <= inj_valid ? inj : pipe1;
    end
  end

  assign {reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in} = pipe2;

  // Reference: what a register at each mapped address holds.
  logic [31:0] ref_mem [logic [22:0]];

  int checks = 0;
  int errors = 0;

  // Observations from one access.
  logic        obs_iss_req, obs_iss_ack, obs_iss_rd, obs_busy0, obs_busy_after, obs_ack_after;
  logic [22:0] obs_iss_addr;
  logic [31:0] obs_iss_data, obs_data, obs_held;
  logic [1:0]  obs_iss_src, obs_status;
  int          obs_lat, obs_acks, obs_req_cycles;

  // Drives one host access starting at a negedge and records what the DUT did; no checking.
  task automatic run_access(input logic rd, input logic [22:0] addr, input logic [31:0] wdata,
                            input int inject_at, input int poke_at, input int late_after,
                            input int post);
    core_reg_req = 1'b1; core_reg_rd_wr_L = rd; core_reg_addr = addr; core_reg_wr_data = wdata;
    @(posedge clk);
    @(negedge clk);
    core_reg_req = 1'b0; core_reg_rd_wr_L = ~rd;
    core_reg_addr = 23'($urandom); core_reg_wr_data = $urandom;
    obs_iss_req = reg_req_out; obs_iss_ack = reg_ack_out; obs_iss_rd = reg_rd_wr_L_out;
    obs_iss_addr = reg_addr_out; obs_iss_data = reg_data_out; obs_iss_src = reg_src_out;
    obs_busy0 = core_reg_busy;
    obs_req_cycles = int'(reg_req_out);
    obs_acks = 0; obs_lat = -1; obs_busy_after = 1'b1; obs_ack_after = 1'b1;
    obs_data = '0; obs_status = '0; obs_held = '0;
    for (int k = 1; k <= BUDGET; k++) begin
      inj_valid = (k == inject_at) || (obs_lat > 0 && late_after > 0 && k == obs_lat + late_after);
      core_reg_req = (k == poke_at);
      @(posedge clk);
      @(negedge clk);
      inj_valid = 1'b0; core_reg_req = 1'b0;
      if (reg_req_out) obs_req_cycles++;
      if (core_reg_ack) begin
        obs_acks++;
        if (obs_lat < 0) begin obs_lat = k; obs_data = core_reg_rd_data; obs_status = core_reg_status; end
      end
      if (obs_lat > 0 && k == obs_lat + 1) begin
        obs_busy_after = core_reg_busy; obs_ack_after = core_reg_ack; obs_held = core_reg_rd_data;
      end
      if (obs_lat > 0 && k >= obs_lat + post) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; ring_init = 1'b1; inj_valid = 1'b0; drop_mode = 1'b0; inj = '0;
    core_reg_req = 1'b0; core_reg_rd_wr_L = 1'b0; core_reg_addr = '0; core_reg_wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (all_out !== 96'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", all_out); end
    reset = 1'b1; ring_init = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (core_reg_busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", core_reg_busy); end
  endtask

  task automatic test_read_hit();
    run_access(1'b1, 23'h000010, 32'h0, 0, 0, 0, 1);
    checks++; if (obs_iss_req !== 1'b1) begin errors++; $display("FAIL hit_req_out got %b want 1", obs_iss_req); end
    checks++; if (obs_iss_src !== MY_SRC) begin errors++; $display("FAIL hit_src got %0d want %0d", obs_iss_src, MY_SRC); end
    checks++; if (obs_iss_rd !== 1'b1 || obs_iss_ack !== 1'b0) begin errors++; $display("FAIL hit_rd_ack_out got %b%b want 10", obs_iss_rd, obs_iss_ack); end
    checks++; if (obs_iss_addr !== 23'h10 || obs_iss_data !== 32'h0) begin errors++; $display("FAIL hit_addr_data got %h/%h want 10/0", obs_iss_addr, obs_iss_data); end
    checks++; if (obs_busy0 !== 1'b1) begin errors++; $display("FAIL hit_busy got %b want 1", obs_busy0); end
    checks++; if (obs_req_cycles !== 1) begin errors++; $display("FAIL hit_req_pulses got %0d want 1", obs_req_cycles); end
    checks++; if (obs_lat !== RING_DELAY + 1) begin errors++; $display("FAIL hit_latency got %0d want %0d", obs_lat, RING_DELAY + 1); end
    checks++; if (obs_data !== ref_mem[23'h10] || obs_status !== 2'b00) begin errors++; $display("FAIL hit_data got %h/%b want %h/00", obs_data, obs_status, ref_mem[23'h10]); end
    checks++; if (obs_busy_after !== 1'b0 || obs_ack_after !== 1'b0) begin errors++; $display("FAIL hit_resp_exit busy/ack got %b%b want 00", obs_busy_after, obs_ack_after); end
    checks++; if (obs_held !== obs_data) begin errors++; $display("FAIL hit_data_hold got %h want %h", obs_held, obs_data); end
  endtask

  task automatic test_write();
    run_access(1'b0, 23'h000020, 32'hCAFE_F00D, 0, 0, 0, 1);
    ref_mem[23'h20] = 32'hCAFE_F00D;
    checks++; if (obs_iss_rd !== 1'b0 || obs_iss_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr_issue got %b/%h want 0/cafef00d", obs_iss_rd, obs_iss_data); end
    checks++; if (obs_status !== 2'b00 || obs_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr_resp got %h/%b want cafef00d/00", obs_data, obs_status); end
    run_access(1'b1, 23'h000020, 32'h0, 0, 0, 0, 1);
    checks++; if (obs_data !== ref_mem[23'h20]) begin errors++; $display("FAIL wr_readback got %h want %h", obs_data, ref_mem[23'h20]); end
  endtask

  task automatic test_noack();
    run_access(1'b1, 23'h7FFFFF, 32'h0, 0, 0, 0, 1);
    checks++; if (obs_data !== NOACK_VAL || obs_status !== 2'b01) begin errors++; $display("FAIL noack got %h/%b want %h/01", obs_data, obs_status, NOACK_VAL); end
    checks++; if (obs_lat !== RING_DELAY + 1) begin errors++; $display("FAIL noack_latency got %0d want %0d", obs_lat, RING_DELAY + 1); end
  endtask

  task automatic test_timeout();
    drop_mode = 1'b1;
    inj = {1'b1, 1'b1, 1'b1, 23'h000030, 32'h0BAD_0BAD, MY_SRC};
    run_access(1'b1, 23'h000030, 32'h0, 0, 0, 2, 6);
    drop_mode = 1'b0;
    checks++; if (obs_lat !== 1 + TMO) begin errors++; $display("FAIL tmo_latency got %0d want %0d", obs_lat, 1 + TMO); end
    checks++; if (obs_data !== TMO_VAL || obs_status !== 2'b10) begin errors++; $display("FAIL tmo_resp got %h/%b want %h/10", obs_data, obs_status, TMO_VAL); end
    checks++; if (obs_acks !== 1) begin errors++; $display("FAIL tmo_late_return acks got %0d want 1", obs_acks); end
    checks++; if (core_reg_busy !== 1'b0) begin errors++; $display("FAIL tmo_idle_busy got %b want 0", core_reg_busy); end
  endtask

  task automatic test_filter_busy();
    inj = {1'b1, 1'b1, 1'b1, 23'h000040, 32'h0BAD_BAD0, 2'd2};
    run_access(1'b1, 23'h000040, 32'h0, 2, 2, 0, 6);
    checks++; if (obs_acks !== 1 || obs_req_cycles !== 1) begin errors++; $display("FAIL filt_src acks/reqs got %0d/%0d want 1/1", obs_acks, obs_req_cycles); end
    checks++; if (obs_data !== ref_mem[23'h40] || obs_lat !== RING_DELAY + 1) begin errors++; $display("FAIL filt_src_data got %h@%0d want %h@%0d", obs_data, obs_lat, ref_mem[23'h40], RING_DELAY + 1); end
    inj = {1'b1, 1'b1, 1'b1, 23'h000060, 32'h0BAD_BAD1, MY_SRC};
    run_access(1'b1, 23'h000050, 32'h0, 2, 3, 0, 6);
    checks++; if (obs_acks !== 1 || obs_req_cycles !== 1) begin errors++; $display("FAIL filt_addr acks/reqs got %0d/%0d want 1/1", obs_acks, obs_req_cycles); end
    checks++; if (obs_data !== ref_mem[23'h50] || obs_status !== 2'b00) begin errors++; $display("FAIL filt_addr_data got %h/%b want %h/00", obs_data, obs_status, ref_mem[23'h50]); end
  endtask

  task automatic test_reset_mid_wait();
    int acks_seen;
    int busy_seen;
    core_reg_req = 1'b1; core_reg_rd_wr_L = 1'b1; core_reg_addr = 23'h000070; core_reg_wr_data = '0;
    @(posedge clk);
    @(negedge clk);
    core_reg_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (all_out !== 96'd0) begin errors++; $display("FAIL async_reset got %h want 0", all_out); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    acks_seen = 0; busy_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (core_reg_ack) acks_seen++;
      if (core_reg_busy) busy_seen++;
    end
    checks++; if (acks_seen !== 0 || busy_seen !== 0) begin errors++; $display("FAIL reset_abandon acks/busy got %0d/%0d want 0/0", acks_seen, busy_seen); end
    run_access(1'b1, 23'h000070, 32'h0, 0, 0, 0, 1);
    checks++; if (obs_data !== ref_mem[23'h70] || obs_status !== 2'b00 || obs_lat !== RING_DELAY + 1) begin errors++; $display("FAIL post_reset got %h/%b@%0d want %h/00@%0d", obs_data, obs_status, obs_lat, ref_mem[23'h70], RING_DELAY + 1); end
  endtask

  // Random back-to-back reads/writes over mapped and unmapped addresses.
  task automatic test_back_to_back();
    logic        rd;
    logic [22:0] a;
    logic [31:0] wd, exp_d;
    logic [1:0]  exp_st;
    for (int n = 0; n < 24; n++) begin
      rd = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? (23'h7FF000 | 23'($urandom_range(0, 4095)))
                                        : 23'($urandom_range(1, 8) * 16);
      wd = $urandom;
      if (ref_mem.exists(a)) begin
        exp_st = 2'b00;
        exp_d  = rd ? ref_mem[a] : wd;
        if (!rd) ref_mem[a] = wd;
      end else begin
        exp_st = 2'b01;
        exp_d  = NOACK_VAL;
      end
      run_access(rd, a, wd, 0, 0, 0, 1);
      checks++; if (obs_iss_data !== (rd ? 32'h0 : wd) || obs_iss_addr !== a) begin errors++; $display("FAIL b2b_issue[%0d] got %h/%h want %h/%h", n, obs_iss_addr, obs_iss_data, a, rd ? 32'h0 : wd); end
      checks++; if (obs_data !== exp_d || obs_status !== exp_st) begin errors++; $display("FAIL b2b_resp[%0d] addr %h got %h/%b want %h/%b", n, a, obs_data, obs_status, exp_d, exp_st); end
      checks++; if (obs_lat !== RING_DELAY + 1) begin errors++; $display("FAIL b2b_latency[%0d] got %0d want %0d", n, obs_lat, RING_DELAY + 1); end
    end
  endtask

  initial begin
    ref_mem[23'h10] = 32'h1234_5678;
    for (int i = 1; i < 8; i++) ref_mem[23'((i + 1) * 16)] = 32'hA5A5_0000 | 32'(i);
    test_reset();
    test_read_hit();
    test_write();
    test_noack();
    test_timeout();
    test_filter_busy();
    test_back_to_back();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/udp_reg_ring_master.md
Name: udp_reg_ring_master

Overview:
- Initiator and terminator of the user-datapath register ring.
- Accepts one host register access at a time and launches it as a single-cycle request into the head of the daisy chain of register blocks.
- Collects the request when it returns at the tail of the ring and reports data and status back to the host-side requester.
- Detects unclaimed addresses (no ack) and lost requests (timeout).

Parameters:
- UDP_REG_SRC_WIDTH, 2: width of the ring source tag.
- SRC_ID, 0: source tag this master stamps on its requests and accepts on return.
- TIMEOUT, 1024: cycles in WAIT before the access is abandoned; must be >= 2.
- NOACK_DATA, 32'hDEAD_0001: read data returned when a request comes back un-acked.
- TIMEOUT_DATA, 32'hDEAD_0000: read data returned on timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- core_reg_req  in  1  single-cycle access strobe; honoured only when core_reg_busy=0.
- core_reg_rd_wr_L  in  1  1 = read, 0 = write.
- core_reg_addr  in  `UDP_REG_ADDR_WIDTH  target register address.
- core_reg_wr_data  in  `CPCI_NF2_DATA_WIDTH  write data.
- core_reg_busy  out  1  high whenever state != IDLE.
- core_reg_ack  out  1  single-cycle completion strobe.
- core_reg_rd_data  out  `CPCI_NF2_DATA_WIDTH  completion data; valid only with core_reg_ack.
- core_reg_status  out  2  00 = ok, 01 = no-ack, 10 = timeout; valid only with core_reg_ack.
- reg_req_out, reg_ack_out, reg_rd_wr_L_out  out  1 each  to ring head.
- reg_addr_out  out  `UDP_REG_ADDR_WIDTH  to ring head.
- reg_data_out  out  `CPCI_NF2_DATA_WIDTH  to ring head.
- reg_src_out  out  UDP_REG_SRC_WIDTH  to ring head.
- reg_req_in, reg_ack_in, reg_rd_wr_L_in  in  1 each  from ring tail.
- reg_addr_in  in  `UDP_REG_ADDR_WIDTH  from ring tail.
- reg_data_in  in  `CPCI_NF2_DATA_WIDTH  from ring tail.
- reg_src_in  in  UDP_REG_SRC_WIDTH  from ring tail.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous):
  - state goes to IDLE; timer and all outputs are 0, including core_reg_busy.
  - Deassertion takes effect at the next clk edge.
  - Reset mid-access abandons the access silently: no ack is issued.
- IDLE:
  - On core_reg_req=1, latch rd_wr_L, addr and wr_data (forced to 0 for reads), then go to ISSUE.
  - core_reg_busy rises in the next cycle.
  - Any reg_req_in seen in IDLE (for example a late return after a timeout) is dropped.
- ISSUE (exactly 1 cycle):
  - Drive reg_req_out=1, reg_ack_out=0, reg_rd_wr_L_out / reg_addr_out / reg_data_out from the latched values, and reg_src_out=SRC_ID.
  - Clear the timer and go to WAIT.
  - In every other state all reg_*_out are 0.
  - reg_req_out is therefore high for exactly one cycle per access: the cycle after core_reg_req was sampled.
- WAIT:
  - The timer increments every cycle.
  - Match = reg_req_in=1 && reg_src_in==SRC_ID && reg_addr_in==latched addr.
  - On match with reg_ack_in=1: rd_data = reg_data_in (also captured for writes), status = 00.
  - On match with reg_ack_in=0: rd_data = NOACK_DATA, status = 01.
  - If timer == TIMEOUT-1 with no match: rd_data = TIMEOUT_DATA, status = 10.
  - Match and timeout in the same cycle: the match wins.
  - reg_req_in with a mismatched source or address is dropped; it is neither forwarded nor counted, and the timer keeps running.
  - On any exit from WAIT, register core_reg_ack=1 with data and status, then go to RESP.
- RESP (exactly 1 cycle):
  - core_reg_ack, core_reg_rd_data and core_reg_status are valid.
  - On the next edge, core_reg_ack=0 and state goes to IDLE; core_reg_busy falls in the same cycle.
  - core_reg_rd_data and core_reg_status are held until the next ack.
- Latency: sample core_reg_req at edge N → reg_req_out high in cycle N+1. Return sampled at edge M → core_reg_ack high in cycle M+1. Back-to-back: a new core_reg_req is accepted in the first IDLE cycle after RESP.
- core_reg_req while busy: ignored, with no side effects.
- Timer width: clog2(TIMEOUT)+1 bits. It never wraps, because WAIT exits at TIMEOUT-1.

Decomposition:
- Shared package/include: status encodings (STATUS_OK, STATUS_NOACK, STATUS_TIMEOUT), state encodings, default NOACK_DATA/TIMEOUT_DATA constants, plus the existing `UDP_REG_ADDR_WIDTH, `CPCI_NF2_DATA_WIDTH and `LOG2_FUNC.
- Single module, no sub-module: the FSM, capture registers and timer fit in about 180 lines.

Test Plan:
- Read hit: ring = 3-cycle delay model acking addr 0x000010 with data 0x12345678; issue read → reg_req_out pulses 1 cycle with src=SRC_ID; core_reg_ack arrives with rd_data=0x12345678, status=00, 5 cycles after the strobe.
- Write: write 0xCAFEF00D to 0x000020 → reg_rd_wr_L_out=0 and reg_data_out=0xCAFEF00D during ISSUE; acked return gives status=00.
- No-ack: read unmapped 0x7FFFFF; ring returns ack=0 → rd_data=0xDEAD0001, status=01.
- Timeout: TIMEOUT=16, ring drops the request → ack exactly 16 cycles after entering WAIT, rd_data=0xDEAD0000, status=10. A late return 2 cycles later is ignored (no second ack).
- Filtering and busy: a foreign-src return during WAIT is ignored, and a core_reg_req pulsed while busy is dropped. Exactly one ack results, carrying the correct data.
- Reset mid-WAIT: reset=0 for 2 cycles → all outputs 0 immediately (asynchronous); no ack is issued; the next access completes normally.
